// File: rtl/dcp_noc_decoder_if.sv
// NoC input link plus decoded-packet bundle for dcp_noc_decoder.
// master = decoder side, slave = NoC source / DCP consumer side.
interface dcp_noc_decoder_if #(
  parameter int MAX_DATA = 8,
  parameter int CNT_W    = 4
);
  localparam int NOC_DATA_WIDTH   = 64;
  localparam int NOC_CHIPID_WIDTH = 14;
  localparam int NOC_X_WIDTH      = 8;
  localparam int NOC_Y_WIDTH      = 8;
  localparam int NOC_FBITS_WIDTH  = 4;
  localparam int MSG_TYPE_WIDTH   = 8;
  localparam int MSG_MSHRID_WIDTH = 8;
  localparam int MSG_LENGTH_WIDTH = 8;
  localparam int PHY_ADDR_WIDTH   = 40;

  logic                               noc_in_val;
  logic [NOC_DATA_WIDTH-1:0]          noc_in_data;
  logic                               noc_in_rdy;
  logic                               dec_val;
  logic                               dec_ack;
  logic [MSG_TYPE_WIDTH-1:0]          dec_type;
  logic [MSG_MSHRID_WIDTH-1:0]        dec_mshrid;
  logic [MSG_LENGTH_WIDTH-1:0]        dec_length;
  logic                               dec_resp;
  logic [PHY_ADDR_WIDTH-1:0]          dec_address;
  logic [15:0]                        dec_options_2;
  logic [NOC_CHIPID_WIDTH-1:0]        dec_src_chipid;
  logic [NOC_X_WIDTH-1:0]             dec_src_x;
  logic [NOC_Y_WIDTH-1:0]             dec_src_y;
  logic [NOC_FBITS_WIDTH-1:0]         dec_src_fbits;
  logic [MAX_DATA*NOC_DATA_WIDTH-1:0] dec_data;
  logic [CNT_W-1:0]                   dec_data_cnt;
  logic                               dec_overflow;
  logic                               drop_pulse;

  modport master (
    input  noc_in_val, noc_in_data, dec_ack,
    output noc_in_rdy, dec_val, dec_type, dec_mshrid, dec_length, dec_resp,
           dec_address, dec_options_2, dec_src_chipid, dec_src_x, dec_src_y,
           dec_src_fbits, dec_data, dec_data_cnt, dec_overflow, drop_pulse
  );

  modport slave (
    output noc_in_val, noc_in_data, dec_ack,
    input  noc_in_rdy, dec_val, dec_type, dec_mshrid, dec_length, dec_resp,
           dec_address, dec_options_2, dec_src_chipid, dec_src_x, dec_src_y,
           dec_src_fbits, dec_data, dec_data_cnt, dec_overflow, drop_pulse
  );
endinterface

// File: rtl/dcp_noc_decoder.sv
// Parses DCP NoC flits into header fields plus a payload buffer, held under valid/ack until consumed.
// Optional DCP_NOC_DECODER_DEST_CHECK_EN: packets not addressed to this tile are consumed and dropped.
module dcp_noc_decoder #(
  parameter int MAX_DATA = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [13:0]       chipid,
  input  logic [7:0]        coreid_x,
  input  logic [7:0]        coreid_y,
  dcp_noc_decoder_if.master bus
);
  localparam int DW = 64;
  localparam logic [7:0] MSG_TYPE_NODATA_ACK = 8'd37;
  localparam logic [7:0] MSG_TYPE_DATA_ACK   = 8'd38;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA);

  typedef enum logic [2:0] {S_HDR1, S_HDR2, S_HDR3, S_PAYLOAD, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [7:0]       rem_q, type_q, mshrid_q, length_q;
  logic             resp_q;
  logic [39:0]      addr_q;
  logic [15:0]      opt2_q;
  logic [13:0]      src_chipid_q;
  logic [7:0]       src_x_q, src_y_q;
  logic [3:0]       src_fbits_q;
  logic [DW-1:0]    data_q [MAX_DATA];
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q, drop_q;

  logic       accept, last, dst_miss, h_resp;
  logic [7:0] h_len, h_type;
  logic       rdy_c, val_c, drop_c;

  assign accept = bus.noc_in_val && (state_q != S_HOLD);
  assign last   = (rem_q == 8'd1);
  assign h_len  = bus.noc_in_data[29:22];
  assign h_type = bus.noc_in_data[21:14];
  assign h_resp = (h_type == MSG_TYPE_DATA_ACK) || (h_type == MSG_TYPE_NODATA_ACK);

`ifdef DCP_NOC_DECODER_DEST_CHECK_EN
  assign dst_miss = (bus.noc_in_data[63:50] != chipid)
                 || (bus.noc_in_data[49:42] != coreid_x)
                 || (bus.noc_in_data[41:34] != coreid_y);
`else
  logic unused_tile_id;
  assign unused_tile_id = ^{chipid, coreid_x, coreid_y};
  assign dst_miss = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_HDR1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR1: if (accept) begin
        if (h_len == 8'd0)          state_d = dst_miss ? S_HDR1 : S_HOLD;
        else if (h_resp || dst_miss) state_d = S_PAYLOAD;
        else                         state_d = S_HDR2;
      end
      S_HDR2:    if (accept) state_d = last ? S_HOLD : S_HDR3;
      S_HDR3:    if (accept) state_d = last ? S_HOLD : S_PAYLOAD;
      S_PAYLOAD: if (accept && last) state_d = drop_q ? S_HDR1 : S_HOLD;
      S_HOLD:    if (bus.dec_ack) state_d = S_HDR1;
      default:   state_d = S_HDR1;
    endcase
  end

  always_comb begin
    rdy_c  = (state_q != S_HOLD);
    val_c  = (state_q == S_HOLD);
    drop_c = accept && (((state_q == S_HDR1) && dst_miss && (h_len == 8'd0))
                     || ((state_q == S_PAYLOAD) && drop_q && last));
  end

  // Header 1 wipes every field so a short packet never exposes a previous packet's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q        <= '0;
      type_q       <= '0;
      mshrid_q     <= '0;
      length_q     <= '0;
      resp_q       <= 1'b0;
      addr_q       <= '0;
      opt2_q       <= '0;
      src_chipid_q <= '0;
      src_x_q      <= '0;
      src_y_q      <= '0;
      src_fbits_q  <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= 1'b0;
      for (int i = 0; i < MAX_DATA; i++) data_q[i] <= '0;
    end else if (accept) begin
      case (state_q)
        S_HDR1: begin
          rem_q        <= h_len;
          type_q       <= h_type;
          mshrid_q     <= bus.noc_in_data[13:6];
          length_q     <= h_len;
          resp_q       <= h_resp;
          addr_q       <= '0;
          opt2_q       <= '0;
          src_chipid_q <= '0;
          src_x_q      <= '0;
          src_y_q      <= '0;
          src_fbits_q  <= '0;
          cnt_q        <= '0;
          ovf_q        <= 1'b0;
          drop_q       <= dst_miss;
          for (int i = 0; i < MAX_DATA; i++) data_q[i] <= '0;
        end
        S_HDR2: begin
          rem_q  <= rem_q - 8'd1;
          addr_q <= bus.noc_in_data[39:0];
          opt2_q <= bus.noc_in_data[55:40];
        end
        S_HDR3: begin
          rem_q        <= rem_q - 8'd1;
          src_chipid_q <= bus.noc_in_data[63:50];
          src_x_q      <= bus.noc_in_data[49:42];
          src_y_q      <= bus.noc_in_data[41:34];
          src_fbits_q  <= bus.noc_in_data[33:30];
        end
        S_PAYLOAD: begin
          rem_q <= rem_q - 8'd1;
          if (!drop_q) begin
            if (cnt_q < MAX_CNT) begin
              for (int i = 0; i < MAX_DATA; i++)
                if (cnt_q == CNT_W'(i)) data_q[i] <= bus.noc_in_data;
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.noc_in_rdy     = rdy_c;
  assign bus.dec_val        = val_c;
  assign bus.drop_pulse     = drop_c;
  assign bus.dec_type       = type_q;
  assign bus.dec_mshrid     = mshrid_q;
  assign bus.dec_length     = length_q;
  assign bus.dec_resp       = resp_q;
  assign bus.dec_address    = addr_q;
  assign bus.dec_options_2  = opt2_q;
  assign bus.dec_src_chipid = src_chipid_q;
  assign bus.dec_src_x      = src_x_q;
  assign bus.dec_src_y      = src_y_q;
  assign bus.dec_src_fbits  = src_fbits_q;
  assign bus.dec_data_cnt   = cnt_q;
  assign bus.dec_overflow   = ovf_q;

  for (genvar g = 0; g < MAX_DATA; g++) begin : g_slot
    assign bus.dec_data[g*DW +: DW] = data_q[g];
  end
endmodule

// File: doc/dcp_noc_decoder.md
Name: dcp_noc_decoder

Overview:
- Receive-side counterpart of the DCP NoC packet encoder. It accepts incoming NoC flits (headers plus payload) on a valid/ready link and parses header fields into registers.
- It buffers up to MAX_DATA payload flits and presents one complete decoded packet to the DCP core logic under a valid/ack handshake.
- Sits between the NoC input port and the DCP request/response handling logic.

Parameters:
MAX_DATA, 8, payload flit buffer depth (flits); power of two, at least 1.
CNT_W, 4, width of payload count output; must hold MAX_DATA.

Ports:
clk  in  1  clock.
rst_n  in  1  reset; asynchronous, active-low.
noc_in_val  in  1  flit valid from NoC.
noc_in_data  in  NOC_DATA_WIDTH  flit.
noc_in_rdy  out  1  decoder accepts flit this cycle.
chipid  in  NOC_CHIPID_WIDTH  own chip id; used only with the optional feature.
coreid_x  in  NOC_X_WIDTH  own x; used only with the optional feature.
coreid_y  in  NOC_Y_WIDTH  own y; used only with the optional feature.
dec_val  out  1  decoded packet valid.
dec_ack  in  1  consumer takes packet.
dec_type  out  MSG_TYPE_WIDTH  message type from header 1.
dec_mshrid  out  MSG_MSHRID_WIDTH  MSHR id from header 1.
dec_length  out  MSG_LENGTH_WIDTH  header-1 length field.
dec_resp  out  1  1 = response format (header 1 only).
dec_address  out  PHY_ADDR_WIDTH  header-2 address (request format only).
dec_options_2  out  16  header-2 options (request format only).
dec_src_chipid  out  NOC_CHIPID_WIDTH  header-3 source chip (request format only).
dec_src_x  out  NOC_X_WIDTH  header-3 source x (request format only).
dec_src_y  out  NOC_Y_WIDTH  header-3 source y (request format only).
dec_src_fbits  out  NOC_FBITS_WIDTH  header-3 source fbits (request format only).
dec_data  out  MAX_DATA*NOC_DATA_WIDTH  payload; flit i occupies slice i.
dec_data_cnt  out  CNT_W  payload flits stored.
dec_overflow  out  1  payload exceeded MAX_DATA.
drop_pulse  out  1  one-cycle pulse when a packet is discarded (optional feature).

Behaviour:
- States: HDR1, HDR2, HDR3, PAYLOAD, HOLD. Reset enters HDR1.
- Reset values: all outputs 0; all field registers, count, and overflow cleared.
- Flit acceptance: a flit is accepted when noc_in_val && noc_in_rdy.
- noc_in_rdy = 1 in every state except HOLD.
- remaining counter is loaded from MSG_LENGTH on header 1 and decremented on every subsequent accepted flit.
- HDR1 accept:
  - Capture MSG_TYPE, MSG_MSHRID, MSG_LENGTH.
  - dec_resp = (type == MSG_TYPE_DATA_ACK || type == MSG_TYPE_NODATA_ACK).
  - Clear data_cnt and overflow.
  - If length==0, go to HOLD. Else go to PAYLOAD if resp, otherwise HDR2.
- HDR2 accept: capture MSG_ADDR_ and MSG_OPTIONS_2_. If remaining==1 go to HOLD, else HDR3.
- HDR3 accept: capture MSG_SRC_CHIPID_, MSG_SRC_X_, MSG_SRC_Y_, MSG_SRC_FBITS_. If remaining==1 go to HOLD, else PAYLOAD.
- PAYLOAD accept:
  - If data_cnt < MAX_DATA, write the flit to slot data_cnt and increment data_cnt.
  - Otherwise discard the flit and set overflow (sticky until the next HDR1).
  - When remaining==1, go to HOLD.
- HOLD:
  - dec_val=1; all dec_* outputs are stable.
  - When dec_ack=1, go to HDR1 next cycle and drop dec_val; no flit is accepted in the ack cycle.
  - dec_ack outside HOLD is ignored.
- Latency: dec_val rises the cycle after the last flit is accepted. Minimum packet period is length+2 cycles.
- Request-format packet with length 1 (HDR2 only): src fields are held at 0.
- Fields not written by the current packet hold 0, not stale values. Clear them on HDR1 accept.
- noc_in_val low mid-packet: stall in the current state, with no timeout.
- Reset mid-packet: returns to HDR1 immediately; the partial packet is lost and dec_val drops asynchronously.

Optional Feature:
- Macro: DCP_NOC_DECODER_DEST_CHECK_EN.
- Enabled:
  - On HDR1 accept, compare MSG_DST_CHIPID/X/Y to chipid/coreid_x/coreid_y.
  - On mismatch, consume all length remaining flits without storing them.
  - Then return to HDR1 without entering HOLD, and pulse drop_pulse for one cycle on the last flit (or on HDR1 itself when length==0).
- Disabled: no comparison; drop_pulse tied 0; chipid/coreid inputs unused.

Test Plan:
- Reset then idle: noc_in_rdy=1, dec_val=0, all outputs 0.
- Response, length=2, data A5A5…, 5A5A…: dec_val one cycle after flit 3; dec_resp=1, data_cnt=2, slots 0/1 match.
- Request, length=2, address 0x80_0000_1000, src x=3 y=2 fbits=0: dec_resp=0, fields match, data_cnt=0.
- Request, length=12 with MAX_DATA=8: first 8 payload flits stored, dec_overflow=1, data_cnt=8, noc_in_rdy remains 1 until HOLD.
- Hold dec_ack low for 5 cycles with the next packet's noc_in_val=1: noc_in_rdy=0 throughout and outputs stable. After ack, the next packet decodes correctly with fields cleared.
- DEST_CHECK_EN with dst x=1 vs coreid_x=0, length=3: 4 flits consumed, drop_pulse=1 once, dec_val never asserted.
